rggen_external_register_ex: RTL and testbench
=============================================

Name: rggen_external_register_ex

Overview:
- Next-generation external-register bridge.
- Forwards matched register accesses to an external bus master port.
- Adds three things the base bridge lacks:
  - per-direction access restriction with error response;
  - programmable response timeout;
  - a registered response stage that decouples register_if timing from the external bus.
- Sits between the register-block bus slave and an external sub-block, one instance per external address window.

Parameters:
- ADDRESS_WIDTH, 8, register/bus address width.
- BUS_WIDTH, 32, data width.
- VALUE_WIDTH, BUS_WIDTH, width of register_if.value.
- STROBE_WIDTH, BUS_WIDTH/8, bus_if strobe width; if equal to BUS_WIDTH, the strobe is per bit, otherwise per byte.
- START_ADDRESS, 0, window base address.
- BYTE_SIZE, 0, window size in bytes.
- READABLE, 1, reads forwarded when 1; error response when 0.
- WRITABLE, 1, writes forwarded when 1; error response when 0.
- TIMEOUT_CYCLES, 0, max cycles bus_if.valid may wait for ready; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- register_if  rggen_register_if.register  -  register-side access and response.
- bus_if  rggen_bus_if.master  -  external request and response.
- o_busy  out  1  high while a transaction is outstanding (state != IDLE).
- o_timeout  out  1  one-cycle pulse when a timeout fires.

Behaviour:
- Reset and clock: reset is i_rst_n, asynchronous, active-low; clock is i_clk. Reset values:
  - state IDLE;
  - bus_if.valid=0, bus_if.address=0, bus_if.access=RGGEN_READ;
  - response status=RGGEN_OKAY, response data=0;
  - o_timeout=0; timeout counter=0.
  - Reset mid-transaction aborts immediately; no response is given.
- Address decode: rggen_address_decoder with READABLE=1 and WRITABLE=1, so a disallowed access type still matches. register_if.active = match (combinational).
- Allowed access: (access is read && READABLE) || (access is write && WRITABLE).
- State IDLE:
  - On register_if.valid && match && allowed, capture on the same edge:
    - bus_if.address = register_if.address - START_ADDRESS (mod 2^ADDRESS_WIDTH);
    - bus_if.access, bus_if.write_data;
    - bus_if.strobe: byte i = OR of register strobe bits [8i+7:8i], or a direct copy when STROBE_WIDTH == BUS_WIDTH.
  - Set bus_if.valid=1, clear the counter, go to REQUEST.
  - On valid && match && !allowed: load status=RGGEN_SLAVE_ERROR and data=0, go to RESPOND. No bus request is issued.
- State REQUEST: bus_if.valid held at 1 and payload stable.
  - If bus_if.ready: capture bus_if.status and bus_if.read_data, set valid=0, go to RESPOND.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: set valid=0, status=RGGEN_SLAVE_ERROR, data=0, o_timeout=1 for one cycle, go to RESPOND.
  - Else counter+1. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Ready and timeout in the same cycle: ready wins and no timeout is flagged.
- State RESPOND:
  - register_if.ready=1 for exactly one cycle.
  - register_if.status, read_data and value are driven from the response registers; value = VALUE_WIDTH'(data).
  - Always returns to IDLE.
  - The upstream drops valid after ready, so no re-issue occurs.
- register_if.ready is 0 in IDLE and REQUEST.
- Latency:
  - bus_if.valid rises 1 cycle after register_if.valid.
  - register_if.ready rises 1 cycle after the bus_if.valid&&ready handshake.
  - Error path: ready 1 cycle after valid.
- A late bus ready after a timeout (bus valid already 0) is ignored.
- Unmatched accesses: no state change; active=0.

Decomposition:
- Shared package rggen_rtl_pkg: rggen_access (RGGEN_READ/RGGEN_WRITE) and rggen_status (RGGEN_OKAY, RGGEN_SLAVE_ERROR) already exist. Add an enum rggen_ext_state_e {IDLE, REQUEST, RESPOND}.
- Reuse the existing rggen_address_decoder.
- One new sub-module: rggen_timeout_counter (parameter TIMEOUT_CYCLES; clear/enable inputs; expire output; constant 0 when disabled).

Test Plan:
- Write forwarding (START_ADDRESS=8'h40, BYTE_SIZE=16):
  - Stimulus: write 0xDEADBEEF with strobe 0x0000FFFF to address 0x44; slave ready 3 cycles later, status OKAY.
  - Response: bus_if.address=0x04, strobe=4'b0011; register_if.ready exactly 1 cycle after the handshake, status OKAY.
- Read return:
  - Stimulus: read 0x48; slave returns 0x12345678.
  - Response: read_data and value = 0x12345678; bus_if.valid low the cycle after ready.
- Restriction (WRITABLE=0):
  - Stimulus: write 0x40.
  - Response: bus_if.valid never rises; ready 1 cycle later with RGGEN_SLAVE_ERROR and read_data 0.
- Timeout (TIMEOUT_CYCLES=4):
  - Stimulus: slave never ready.
  - Response: valid held 4 cycles then drops; o_timeout pulses once; SLAVE_ERROR response. A ready arriving later is ignored.
- Boundary:
  - Slave ready on exactly the 4th cycle (counter==3): OKAY response, no o_timeout.
  - Access to 0x50 (outside the window): active=0, no request.
- Reset mid-REQUEST:
  - Stimulus: assert i_rst_n low.
  - Response: bus_if.valid=0 and o_busy=0 asynchronously; no register_if.ready; the next access after reset proceeds normally.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared RgGen types: access kinds, response status, external-bridge states,
// and a helper that sizes counters.
package rggen_rtl_pkg;
    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY        = 2'b00,
        RGGEN_SLAVE_ERROR = 2'b10
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPOND
    } rggen_ext_state_e;

    // Width able to hold 0..cycles, never narrower than one bit.
    function automatic int rggen_counter_width(int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/rggen_bus_if.sv
// Simple valid/ready bus toward an external sub-block.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int STROBE_WIDTH  = BUS_WIDTH / 8
);
    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [STROBE_WIDTH-1:0]  strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );
    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_register_if.sv
// Register-side access/response bundle between the bus slave and register blocks.
interface rggen_register_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int VALUE_WIDTH   = BUS_WIDTH
);
    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH-1:0]     strobe;
    logic                     active;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;
    logic [VALUE_WIDTH-1:0]   value;

    modport host (
        output valid, access, address, write_data, strobe,
        input  active, ready, status, read_data, value
    );
    modport register (
        input  valid, access, address, write_data, strobe,
        output active, ready, status, read_data, value
    );
endinterface

// File: rtl/rggen_address_decoder.sv
// Window match: address inside [START_ADDRESS, START_ADDRESS+BYTE_SIZE) and access type permitted.
module rggen_address_decoder
    import rggen_rtl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 8,
    parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
    parameter int                     BYTE_SIZE     = 0,
    parameter bit                     READABLE      = 1'b1,
    parameter bit                     WRITABLE      = 1'b1
)(
    input  rggen_access              access,
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic                     match
);
    localparam int                   EXT_W = ADDRESS_WIDTH + 1;
    localparam logic [EXT_W-1:0]     SIZE  = EXT_W'(BYTE_SIZE);

    logic [EXT_W-1:0] offset;
    logic             access_ok;

    // One extra bit turns an address below the base into a huge offset.
    assign offset    = {1'b0, address} - {1'b0, START_ADDRESS};
    assign access_ok = (access == RGGEN_READ) ? READABLE : WRITABLE;
    assign match     = (offset < SIZE) && access_ok;
endmodule

// File: rtl/rggen_timeout_counter.sv
// Counts cycles a request waits; expire flags the last allowed cycle.
// With TIMEOUT_CYCLES == 0 the expire output is constant 0.
module rggen_timeout_counter
    import rggen_rtl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int                     COUNT_W = rggen_counter_width(TIMEOUT_CYCLES);
    localparam bit                     ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [COUNT_W-1:0]     LAST    = COUNT_W'(ENABLED ? TIMEOUT_CYCLES - 1 : 0);

    logic [COUNT_W-1:0] count;

    // Saturates at LAST so an unattended request cannot wrap the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + COUNT_W'(1);
        end
    end

    assign expire = ENABLED && enable && (count == LAST);
endmodule

// File: rtl/rggen_external_register_ex.sv
// External-register bridge with access restriction, request timeout and a
// registered response stage between register_if and the external bus.
module rggen_external_register_ex
    import rggen_rtl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH  = 8,
    parameter int                     BUS_WIDTH      = 32,
    parameter int                     VALUE_WIDTH    = BUS_WIDTH,
    parameter int                     STROBE_WIDTH   = BUS_WIDTH / 8,
    parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS  = '0,
    parameter int                     BYTE_SIZE      = 0,
    parameter bit                     READABLE       = 1'b1,
    parameter bit                     WRITABLE       = 1'b1,
    parameter int                     TIMEOUT_CYCLES = 0
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    rggen_register_if.register register_if,
    rggen_bus_if.master        bus_if,
    output logic               o_busy,
    output logic               o_timeout
);
    rggen_ext_state_e         state;
    logic                     match;
    logic                     allowed;
    logic                     accept;
    logic                     expire;
    logic [STROBE_WIDTH-1:0]  strobe_next;

    logic                     vld_p0;
    rggen_access              access_p0;
    logic [ADDRESS_WIDTH-1:0] address_p0;
    logic [BUS_WIDTH-1:0]     write_data_p0;
    logic [STROBE_WIDTH-1:0]  strobe_p0;

    rggen_status              status_p1;
    logic [BUS_WIDTH-1:0]     data_p1;
    logic                     timeout_p1;

    // Decoder accepts both directions so a forbidden access still answers with an error.
    rggen_address_decoder #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .START_ADDRESS (START_ADDRESS),
        .BYTE_SIZE     (BYTE_SIZE),
        .READABLE      (1'b1),
        .WRITABLE      (1'b1)
    ) u_decoder (
        .access  (register_if.access),
        .address (register_if.address),
        .match   (match)
    );

    rggen_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (state != REQUEST),
        .enable  ((state == REQUEST) && !bus_if.ready),
        .expire  (expire)
    );

    assign allowed = (register_if.access == RGGEN_READ) ? READABLE : WRITABLE;
    assign accept  = (state == IDLE) && register_if.valid && match;

    generate
        if (STROBE_WIDTH == BUS_WIDTH) begin : g_bit_strobe
            assign strobe_next = register_if.strobe;
        end else begin : g_byte_strobe
            always_comb begin
                strobe_next = '0;
                for (int i = 0; i < STROBE_WIDTH; i++) begin
                    strobe_next[i] = |register_if.strobe[8*i+:8];
                end
            end
        end
    endgenerate

    // Stage p0: bus request capture; stage p1: response registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            vld_p0     <= 1'b0;
            address_p0 <= '0;
            access_p0  <= RGGEN_READ;
            status_p1  <= RGGEN_OKAY;
            data_p1    <= '0;
            timeout_p1 <= 1'b0;
        end else begin
            timeout_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && allowed) begin
                        vld_p0     <= 1'b1;
                        address_p0 <= register_if.address - START_ADDRESS;
                        access_p0  <= register_if.access;
                        state      <= REQUEST;
                    end else if (accept) begin
                        status_p1 <= RGGEN_SLAVE_ERROR;
                        data_p1   <= '0;
                        state     <= RESPOND;
                    end
                end
                REQUEST: begin
                    if (bus_if.ready) begin
                        vld_p0    <= 1'b0;
                        status_p1 <= bus_if.status;
                        data_p1   <= bus_if.read_data;
                        state     <= RESPOND;
                    end else if (expire) begin
                        vld_p0     <= 1'b0;
                        status_p1  <= RGGEN_SLAVE_ERROR;
                        data_p1    <= '0;
                        timeout_p1 <= 1'b1;
                        state      <= RESPOND;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept && allowed) begin
            write_data_p0 <= register_if.write_data;
            strobe_p0     <= strobe_next;
        end
    end

    assign bus_if.valid      = vld_p0;
    assign bus_if.access     = access_p0;
    assign bus_if.address    = address_p0;
    assign bus_if.write_data = write_data_p0;
    assign bus_if.strobe     = strobe_p0;

    assign register_if.active    = match;
    assign register_if.ready     = (state == RESPOND);
    assign register_if.status    = status_p1;
    assign register_if.read_data = data_p1;
    assign register_if.value     = VALUE_WIDTH'(data_p1);

    assign o_busy    = (state != IDLE);
    assign o_timeout = timeout_p1;
endmodule

// File: tb/tb_rggen_external_register_ex.sv
// Bench for rggen_external_register_ex: a full-access bridge with a 4-cycle
// timeout and a write-protected bridge, both on window 0x40..0x4F.
module tb_rggen_external_register_ex;
    import rggen_rtl_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, tmo, busy2, tmo2;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    rggen_register_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .VALUE_WIDTH(32)) rif ();
    rggen_bus_if      #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .STROBE_WIDTH(4)) bif ();
    rggen_register_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .VALUE_WIDTH(32)) rif2 ();
    rggen_bus_if      #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .STROBE_WIDTH(4)) bif2 ();

    rggen_external_register_ex #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .VALUE_WIDTH(32), .STROBE_WIDTH(4),
        .START_ADDRESS(8'h40), .BYTE_SIZE(16), .READABLE(1'b1), .WRITABLE(1'b1),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .register_if(rif), .bus_if(bif),
        .o_busy(busy), .o_timeout(tmo)
    );

    rggen_external_register_ex #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .VALUE_WIDTH(32), .STROBE_WIDTH(4),
        .START_ADDRESS(8'h40), .BYTE_SIZE(16), .READABLE(1'b1), .WRITABLE(1'b0),
        .TIMEOUT_CYCLES(0)
    ) dut_ro (
        .i_clk(clk), .i_rst_n(rst_n), .register_if(rif2), .bus_if(bif2),
        .o_busy(busy2), .o_timeout(tmo2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one access on the full bridge; slave answers after dly waiting cycles.
    task automatic do_main(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [31:0] bstrb, input int dly, input bit serr,
                           input logic [31:0] rdata);
        bit          hit;
        bit          timed_out;
        int          n;
        int          pulses;
        logic [3:0]  exp_strb;
        logic [31:0] exp_data;
        rggen_status exp_status;
        hit       = (addr >= 8'h40) && (addr < 8'h50);
        timed_out = (dly >= TMO);
        for (int i = 0; i < 4; i++) exp_strb[i] = ((bstrb >> (8 * i)) & 32'hFF) != 0;
        exp_data   = timed_out ? 32'h0 : rdata;
        exp_status = (timed_out || serr) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

        @(negedge clk);
        bif.ready       = 1'b0;
        rif.valid       = 1'b1;
        rif.access      = wr ? RGGEN_WRITE : RGGEN_READ;
        rif.address     = addr;
        rif.write_data  = wdata;
        rif.strobe      = bstrb;
        #1 chk("active", 64'(rif.active), 64'(hit));
        @(negedge clk);
        if (!hit) begin
            chk("miss_bvalid", 64'(bif.valid), 64'(0));
            chk("miss_busy", 64'(busy), 64'(0));
            chk("miss_ready", 64'(rif.ready), 64'(0));
            rif.valid = 1'b0;
            return;
        end
        chk("bvalid_rise", 64'(bif.valid), 64'(1));
        chk("busy", 64'(busy), 64'(1));
        chk("baddr", 64'(bif.address), 64'(addr - 8'h40));
        chk("baccess", 64'(bif.access), 64'(wr ? RGGEN_WRITE : RGGEN_READ));
        chk("bwdata", 64'(bif.write_data), 64'(wdata));
        chk("bstrobe", 64'(bif.strobe), 64'(exp_strb));

        n = 0;
        pulses = 0;
        while (bif.valid && n < 16) begin
            if (tmo) pulses++;
            if (rif.ready) pulses++;
            if (n == dly) begin
                bif.ready     = 1'b1;
                bif.status    = serr ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
                bif.read_data = rdata;
            end
            @(negedge clk);
            n++;
        end
        chk("vld_cycles", 64'(n), 64'(timed_out ? TMO : dly + 1));
        chk("early_pulse", 64'(pulses), 64'(0));
        chk("rready", 64'(rif.ready), 64'(1));
        chk("timeout", 64'(tmo), 64'(timed_out));
        chk("status", 64'(rif.status), 64'(exp_status));
        chk("rdata", 64'(rif.read_data), 64'(exp_data));
        chk("value", 64'(rif.value), 64'(exp_data));

        rif.valid = 1'b0;
        // After a timeout a late slave ready must be ignored.
        bif.ready     = timed_out;
        bif.read_data = rdata;
        @(negedge clk);
        chk("ready_drop", 64'(rif.ready), 64'(0));
        chk("timeout_drop", 64'(tmo), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_bvalid", 64'(bif.valid), 64'(0));
        bif.ready = 1'b0;
    endtask

    // Reference: one access on the write-protected bridge; slave always ready.
    task automatic do_ro(input bit wr, input logic [7:0] addr, input logic [31:0] rdata);
        @(negedge clk);
        rif2.valid      = 1'b1;
        rif2.access     = wr ? RGGEN_WRITE : RGGEN_READ;
        rif2.address    = addr;
        rif2.write_data = $urandom;
        rif2.strobe     = '1;
        bif2.ready      = 1'b1;
        bif2.status     = RGGEN_OKAY;
        bif2.read_data  = rdata;
        @(negedge clk);
        if (wr) begin
            chk("ro_bvalid", 64'(bif2.valid), 64'(0));
            chk("ro_ready", 64'(rif2.ready), 64'(1));
            chk("ro_status", 64'(rif2.status), 64'(RGGEN_SLAVE_ERROR));
            chk("ro_rdata", 64'(rif2.read_data), 64'(0));
        end else begin
            chk("ro_rd_bvalid", 64'(bif2.valid), 64'(1));
            chk("ro_rd_baddr", 64'(bif2.address), 64'(addr - 8'h40));
            @(negedge clk);
            chk("ro_rd_ready", 64'(rif2.ready), 64'(1));
            chk("ro_rd_status", 64'(rif2.status), 64'(RGGEN_OKAY));
            chk("ro_rd_data", 64'(rif2.read_data), 64'(rdata));
            chk("ro_rd_bvalid_drop", 64'(bif2.valid), 64'(0));
        end
        rif2.valid = 1'b0;
        @(negedge clk);
        chk("ro_idle_ready", 64'(rif2.ready), 64'(0));
        chk("ro_idle_bvalid", 64'(bif2.valid), 64'(0));
        chk("ro_idle_busy", 64'(busy2), 64'(0));
        bif2.ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_strobe();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       s[8*i+:8] = 8'h00;
                1:       s[8*i+:8] = 8'hFF;
                default: s[8*i+:8] = 8'($urandom_range(0, 255));
            endcase
        end
        return s;
    endfunction

    initial begin
        rst_n = 1'b0;
        rif.valid = 1'b0; rif.access = RGGEN_READ; rif.address = '0;
        rif.write_data = '0; rif.strobe = '0;
        bif.ready = 1'b0; bif.status = RGGEN_OKAY; bif.read_data = '0;
        rif2.valid = 1'b0; rif2.access = RGGEN_READ; rif2.address = '0;
        rif2.write_data = '0; rif2.strobe = '0;
        bif2.ready = 1'b0; bif2.status = RGGEN_OKAY; bif2.read_data = '0;
        repeat (2) @(negedge clk);

        chk("rst_bvalid", 64'(bif.valid), 64'(0));
        chk("rst_baddr", 64'(bif.address), 64'(0));
        chk("rst_baccess", 64'(bif.access), 64'(RGGEN_READ));
        chk("rst_ready", 64'(rif.ready), 64'(0));
        chk("rst_status", 64'(rif.status), 64'(RGGEN_OKAY));
        chk("rst_rdata", 64'(rif.read_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_timeout", 64'(tmo), 64'(0));
        chk("rst_ro_bvalid", 64'(bif2.valid), 64'(0));
        rst_n = 1'b1;

        do_main(1'b1, 8'h44, 32'hDEADBEEF, 32'h0000FFFF, 2, 1'b0, 32'h0);
        do_main(1'b0, 8'h48, 32'h0, 32'h0, 0, 1'b0, 32'h12345678);
        do_main(1'b0, 8'h4C, 32'h0, 32'h0, 10, 1'b0, 32'hA5A5A5A5);
        do_main(1'b1, 8'h40, 32'h01020304, 32'hFF000000, 3, 1'b0, 32'h0BADF00D);
        do_main(1'b0, 8'h4F, 32'h0, 32'h0, 1, 1'b1, 32'h55AA55AA);
        do_main(1'b1, 8'h50, 32'h11111111, 32'hFFFFFFFF, 0, 1'b0, 32'h0);
        do_main(1'b0, 8'h3F, 32'h0, 32'h0, 0, 1'b0, 32'h0);

        do_ro(1'b1, 8'h40, 32'hCAFEF00D);
        do_ro(1'b0, 8'h4C, 32'hCAFEF00D);
        do_ro(1'b1, 8'h47, 32'h87654321);

        // Reset in the middle of a pending request.
        @(negedge clk);
        rif.valid = 1'b1; rif.access = RGGEN_READ; rif.address = 8'h4C; bif.ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_bvalid", 64'(bif.valid), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_bvalid", 64'(bif.valid), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_ready", 64'(rif.ready), 64'(0));
        @(negedge clk);
        rif.valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_mid_no_ready", 64'(rif.ready), 64'(0));
        end
        do_main(1'b0, 8'h44, 32'h0, 32'h0, 1, 1'b0, 32'h600DCAFE);

        for (int t = 0; t < 40; t++) begin
            do_main(1'($urandom_range(0, 1)), 8'($urandom_range(56, 87)), $urandom,
                    rand_strobe(), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
